// File: rtl/store_write_buffer.sv
// store_write_buffer: write-through store FIFO between the data cache and the
// data RAM. It drains stores in push order at one per cycle whenever the RAM
// is ready. It also stalls any load whose word address matches a pending
// store, so a cache refill never reads stale RAM data.
// Handshakes:
//   push side  - a store is accepted when push & !full (push_stall = push & full).
//   drain side - mem_wen is valid; the write retires when mem_wen & mem_ready.
//                mem_* stays stable while mem_wen=1 and mem_ready=0.
module store_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_WIDTH-1:0]    push_addr,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic [2:0]               push_width,
    output logic                     push_stall,
    input  logic                     ld_en,
    input  logic [ADDR_WIDTH-1:0]    ld_addr,
    output logic                     ld_stall,
    output logic                     mem_wen,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [2:0]               mem_width,
    input  logic                     mem_ready,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW-1:0]         wr_next, rd_next;
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [DEPTH-1:0]      valid;
    logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem  [DEPTH];
    logic [2:0]            width_mem [DEPTH];
    logic                  push_ok, pop, hit;

    assign wr_idx = wr_ptr[IW-1:0];
    assign rd_idx = rd_ptr[IW-1:0];

    // Full comes from the registered flag, so a same-cycle pop never makes room.
    assign push_ok    = push & ~full;
    assign push_stall = push & full;
    assign pop        = mem_wen & mem_ready;

    assign wr_next = wr_ptr + PW'(push_ok);
    assign rd_next = rd_ptr + PW'(pop);

    // The head entry drives the RAM write port directly.
    assign mem_wen   = valid[rd_idx];
    assign mem_addr  = addr_mem[rd_idx];
    assign mem_wdata = data_mem[rd_idx];
    assign mem_width = width_mem[rd_idx];

    // Word-granular hazard check against every valid entry. An entry popping this cycle still counts.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_mem[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]))
                hit = 1'b1;
        end
        ld_stall = ld_en & hit;
    end

    // Pointers, valid flags and status flags. Reset discards everything, including a write mid-drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) valid[wr_idx] <= 1'b1;
            if (pop)     valid[rd_idx] <= 1'b0;
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            count  <= wr_next - rd_next;
            empty  <= (wr_next == rd_next);
            full   <= (wr_next[IW-1:0] == rd_next[IW-1:0]) && (wr_next[IW] != rd_next[IW]);
        end
    end

    // Entry payload needs no reset; valid flags gate its use.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_idx]  <= push_addr;
            data_mem[wr_idx]  <= push_data;
            width_mem[wr_idx] <= push_width;
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Testbench for store_write_buffer: a table of per-cycle vectors with
// hand-computed outputs, plus hand-written sequences for streaming and reset.
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic [31:0] push_addr, push_data;
    logic [2:0]  push_width;
    logic        push_stall;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_width;
    logic        mem_ready;
    logic        empty, full;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    logic        sb_on = 1'b0;
    logic [63:0] exp_q[$];

    store_write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_addr(push_addr), .push_data(push_data), .push_width(push_width),
        .push_stall(push_stall),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_ready(mem_ready),
        .empty(empty), .full(full), .count(count)
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] pa;
        logic [31:0] pd;
        logic [2:0]  pw;
        logic        ld_en;
        logic [31:0] la;
        logic        mr;
        logic        ps;
        logic        ls;
        logic        wen;
        logic [31:0] ma;
        logic [31:0] md;
        logic [2:0]  mw;
        logic [2:0]  cnt;
        logic        emp;
        logic        fl;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic p, input logic [31:0] pa, input logic [31:0] pd, input logic [2:0] pw,
                     input logic le, input logic [31:0] la, input logic mr,
                     input logic ps, input logic ls, input logic wen,
                     input logic [31:0] ma, input logic [31:0] md, input logic [2:0] mw,
                     input logic [2:0] cnt, input logic emp, input logic fl);
        vec_t t;
        t.push = p; t.pa = pa; t.pd = pd; t.pw = pw; t.ld_en = le; t.la = la; t.mr = mr;
        t.ps = ps; t.ls = ls; t.wen = wen; t.ma = ma; t.md = md; t.mw = mw;
        t.cnt = cnt; t.emp = emp; t.fl = fl;
        vecs.push_back(t);
    endtask

    // driver: apply inputs just after the rising edge
    task automatic drive(input logic r, input logic p, input logic [31:0] pa, input logic [31:0] pd,
                         input logic [2:0] pw, input logic le, input logic [31:0] la, input logic mr);
        @(posedge clk);
        #1;
        rst = r; push = p; push_addr = pa; push_data = pd; push_width = pw;
        ld_en = le; ld_addr = la; mem_ready = mr;
    endtask

    // scoreboard: a write retires at the next rising edge when mem_wen & mem_ready and no reset
    always @(negedge clk) begin
        if (sb_on && !rst && mem_wen && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_write", {mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("sb_write", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; push = 1'b0; push_addr = '0; push_data = '0; push_width = '0;
        ld_en = 1'b0; ld_addr = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // push pa pd pw  ld la  mr | ps ls wen ma md mw cnt emp full
        // reset then idle with mem_ready=1
        v(0, 0, 0, 0,                  0, 0, 1,   0, 0, 0, 0, 0, 0,                  0, 1, 0);
        v(0, 0, 0, 0,                  0, 0, 1,   0, 0, 0, 0, 0, 0,                  0, 1, 0);
        // single SW held off by mem_ready for 3 cycles
        v(1, 32'h100, 32'hDEADBEEF, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 1, 0);
        v(0, 0, 0, 0,                  0, 0, 0,   0, 0, 1, 32'h100, 32'hDEADBEEF, 3'b000, 1, 0, 0);
        v(0, 0, 0, 0,                  0, 0, 0,   0, 0, 1, 32'h100, 32'hDEADBEEF, 3'b000, 1, 0, 0);
        v(0, 0, 0, 0,                  0, 0, 0,   0, 0, 1, 32'h100, 32'hDEADBEEF, 3'b000, 1, 0, 0);
        v(0, 0, 0, 0,                  0, 0, 1,   0, 0, 1, 32'h100, 32'hDEADBEEF, 3'b000, 1, 0, 0);
        v(0, 0, 0, 0,                  0, 0, 0,   0, 0, 0, 0, 0, 0,                  0, 1, 0);
        // five pushes into a DEPTH=4 buffer with RAM stalled
        v(1, 32'hA0, 32'h11, 3'b000,   0, 0, 0,   0, 0, 0, 0, 0, 0,                  0, 1, 0);
        v(1, 32'hA4, 32'h22, 3'b000,   0, 0, 0,   0, 0, 1, 32'hA0, 32'h11, 3'b000,   1, 0, 0);
        v(1, 32'hA8, 32'h33, 3'b001,   0, 0, 0,   0, 0, 1, 32'hA0, 32'h11, 3'b000,   2, 0, 0);
        v(1, 32'hAC, 32'h44, 3'b010,   0, 0, 0,   0, 0, 1, 32'hA0, 32'h11, 3'b000,   3, 0, 0);
        v(1, 32'hB0, 32'h55, 3'b000,   0, 0, 0,   1, 0, 1, 32'hA0, 32'h11, 3'b000,   4, 0, 1);
        // drain: exactly four writes in order, count 4,3,2,1,0
        v(0, 0, 0, 0,                  0, 0, 1,   0, 0, 1, 32'hA0, 32'h11, 3'b000,   4, 0, 1);
        v(0, 0, 0, 0,                  0, 0, 1,   0, 0, 1, 32'hA4, 32'h22, 3'b000,   3, 0, 0);
        v(0, 0, 0, 0,                  0, 0, 1,   0, 0, 1, 32'hA8, 32'h33, 3'b001,   2, 0, 0);
        v(0, 0, 0, 0,                  0, 0, 1,   0, 0, 1, 32'hAC, 32'h44, 3'b010,   1, 0, 0);
        v(0, 0, 0, 0,                  0, 0, 0,   0, 0, 0, 0, 0, 0,                  0, 1, 0);
        // load hazard against a pending SB to 0x203
        v(1, 32'h203, 32'h7F, 3'b010,  1, 32'h200, 0, 0, 0, 0, 0, 0, 0,             0, 1, 0);
        v(0, 0, 0, 0,                  1, 32'h200, 0, 0, 1, 1, 32'h203, 32'h7F, 3'b010, 1, 0, 0);
        v(0, 0, 0, 0,                  1, 32'h204, 0, 0, 0, 1, 32'h203, 32'h7F, 3'b010, 1, 0, 0);
        v(0, 0, 0, 0,                  0, 32'h200, 0, 0, 0, 1, 32'h203, 32'h7F, 3'b010, 1, 0, 0);
        v(0, 0, 0, 0,                  1, 32'h200, 1, 0, 1, 1, 32'h203, 32'h7F, 3'b010, 1, 0, 0);
        v(0, 0, 0, 0,                  1, 32'h200, 0, 0, 0, 0, 0, 0, 0,             0, 1, 0);
        v(0, 0, 0, 0,                  1, 32'h204, 0, 0, 0, 0, 0, 0, 0,             0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b0, vecs[i].push, vecs[i].pa, vecs[i].pd, vecs[i].pw,
                  vecs[i].ld_en, vecs[i].la, vecs[i].mr);
            @(negedge clk);
            check($sformatf("v%0d_push_stall", i), 64'(push_stall), 64'(vecs[i].ps));
            check($sformatf("v%0d_ld_stall", i),   64'(ld_stall),   64'(vecs[i].ls));
            check($sformatf("v%0d_mem_wen", i),    64'(mem_wen),    64'(vecs[i].wen));
            check($sformatf("v%0d_count", i),      64'(count),      64'(vecs[i].cnt));
            check($sformatf("v%0d_empty", i),      64'(empty),      64'(vecs[i].emp));
            check($sformatf("v%0d_full", i),       64'(full),       64'(vecs[i].fl));
            if (vecs[i].wen) begin
                check($sformatf("v%0d_mem_addr", i),  64'(mem_addr),  64'(vecs[i].ma));
                check($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].md));
                check($sformatf("v%0d_mem_width", i), 64'(mem_width), 64'(vecs[i].mw));
            end
        end

        // streaming: fill to 2, then push and pop together; addresses 0x0..0x24 drain in order
        sb_on = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] a;
            a = 32'(k * 4);
            exp_q.push_back({a, a ^ 32'hA5A5_0000});
            drive(1'b0, 1'b1, a, a ^ 32'hA5A5_0000, 3'b000, 1'b0, '0, (k >= 2));
            @(negedge clk);
            if (k >= 3) check($sformatf("stream_count_k%0d", k), 64'(count), 64'd2);
        end
        drive(1'b0, 1'b0, '0, '0, 3'b000, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("stream_count_tail2", 64'(count), 64'd2);
        drive(1'b0, 1'b0, '0, '0, 3'b000, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("stream_count_tail1", 64'(count), 64'd1);
        drive(1'b0, 1'b0, '0, '0, 3'b000, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("stream_count_tail0", 64'(count), 64'd0);
        check("stream_empty", 64'(empty), 64'd1);
        check("stream_all_drained", 64'(exp_q.size()), 64'd0);

        // reset with three pending entries while a write is being presented
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'h300 + 32'(k * 4), 32'h900 + 32'(k), 3'b000, 1'b0, '0, 1'b0);
        end
        drive(1'b1, 1'b0, '0, '0, 3'b000, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("rst_pre_mem_wen", 64'(mem_wen), 64'd1);
        check("rst_pre_count", 64'(count), 64'd3);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, '0, '0, 3'b000, 1'b1, 32'h300, 1'b1);
            @(negedge clk);
            check($sformatf("rst_post_mem_wen_%0d", k), 64'(mem_wen), 64'd0);
            check($sformatf("rst_post_empty_%0d", k), 64'(empty), 64'd1);
            check($sformatf("rst_post_count_%0d", k), 64'(count), 64'd0);
            check($sformatf("rst_post_ld_stall_%0d", k), 64'(ld_stall), 64'd0);
        end
        check("rst_no_writes", 64'(exp_q.size()), 64'd0);
        sb_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Write-through store buffer directly downstream of the data cache and upstream of the data RAM.
- Every store the cache accepts (cacheEn & wen) is also pushed here. The buffer drains the stores to RAM in order, one per cycle, when RAM signals ready.
- A load whose word address matches a pending store is stalled until that store has drained, so the cache refill never reads stale RAM data.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, store data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  store request from the cache stage (cacheEn & wen).
- push_addr  input  ADDR_WIDTH  store byte address.
- push_data  input  DATA_WIDTH  store data, right-aligned.
- push_width  input  3  DataWidth code: 000 SW, 001 SH, 010 SB.
- push_stall  output  1  combinational, equal to push & full; the pipeline holds the store.
- ld_en  input  1  load request in the cache stage.
- ld_addr  input  ADDR_WIDTH  load byte address.
- ld_stall  output  1  combinational; a load hazard against a pending entry.
- mem_wen  output  1  head entry valid; a write is presented to RAM.
- mem_addr  output  ADDR_WIDTH  head entry address.
- mem_wdata  output  DATA_WIDTH  head entry data.
- mem_width  output  3  head entry width code.
- mem_ready  input  1  RAM accepts the presented write this cycle.
- empty  output  1  registered; no pending entries (used for fence/halt).
- full  output  1  registered; count == DEPTH.
- count  output  $clog2(DEPTH)+1  number of pending entries.

Behaviour:
- Storage is a circular FIFO with wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Each entry holds a valid flag, address, data and width.
- Reset (rst high at a clock edge):
  - Pointers return to 0 and all valid flags clear.
  - Outputs: count=0, empty=1, full=0, mem_wen=0.
  - Pending stores are discarded, including those caught mid-drain.
  - rst takes priority over push and pop in the same cycle.
- Push (accepted when push & !full):
  - The entry is written at wr_ptr and wr_ptr increments, wrapping mod 2*DEPTH.
  - The entry is visible on the mem_* outputs no earlier than the next cycle; minimum push-to-mem_wen latency is 1 cycle.
- Push while full: the push is not accepted and no state changes. push_stall=1 in the same cycle.
- A pop in the same cycle as a push does not free space for that push. Full is evaluated on the registered count.
- Pop (occurs when mem_wen & mem_ready):
  - The head's valid flag clears and rd_ptr increments.
  - The next entry is presented the following cycle, so back-to-back drain runs at 1 store/cycle.
- mem_ready while empty: ignored.
- mem_wen/addr/wdata/width are driven directly from the head entry. They are held stable while mem_wen=1 and mem_ready=0.
- Push and pop together with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Load hazard:
  - ld_stall = ld_en & (some valid entry has addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]).
  - Any width matches at word granularity; there is no data forwarding.
  - An entry being popped in the current cycle still counts as matching, so the stall releases on the cycle after the pop.
  - A push in the same cycle as ld_en is not compared.
  - ld_stall is 0 when ld_en=0.
- Ordering: RAM sees stores in exact push order. Multiple stores to the same address are all drained; no merging.
- Widths: the buffer does no lane shifting; data and width pass through unchanged to RAM.
- Pointer wrap: correct for arbitrary sequences. Comparisons use only the low $clog2(DEPTH) bits for indexing and the full width for full/empty.

Test Plan:
- Reset then idle, mem_ready=1 -> empty=1, count=0, mem_wen=0 every cycle.
- Push SW 0x100/0xDEADBEEF, mem_ready=0 for 3 cycles, then mem_ready=1 -> mem_wen=1 from cycle +1 with address/data stable while stalled; single RAM write on the first ready cycle; empty=1 the cycle after.
- Five pushes with mem_ready=0 and DEPTH=4 -> full=1 after 4; fifth push sees push_stall=1 and is not stored. After raising mem_ready, the RAM sees exactly 4 writes in order; count goes 4,3,2,1,0.
- Pending SB to 0x203 -> ld_en to 0x200 gives ld_stall=1 until the cycle after the pop. A load to 0x204 gives ld_stall=0 throughout.
- Continuous push and pop at count=2 for 10 cycles -> count stays 2. The pointers wrap at least twice with order preserved (addresses 0x0..0x24 arrive in sequence).
- rst asserted with 3 pending entries while mem_wen=1 -> next cycle mem_wen=0, empty=1, no further RAM writes.
